// File: rtl/lv_owt_tx_ctrl.sv
// One-wire register-access transmitter: frames a captured SPI write/read request onto a serial line.
// Check field is one even-parity bit, or a CRC-4 when LV_OWT_TX_CRC_EN is defined.
module lv_owt_tx_ctrl #(
    parameter int REG_AW  = 7,
    parameter int REG_DW  = 8,
    parameter int BIT_CYC = 4,
    parameter int GAP_CYC = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_spi_owt_wr_req,
    input  logic              i_spi_owt_rd_req,
    input  logic [REG_AW-1:0] i_spi_owt_addr,
    input  logic [REG_DW-1:0] i_spi_owt_data,
    output logic              o_owt_tx_spi_ack,
    output logic              o_owt_tx_line,
    output logic              o_owt_tx_busy
);

`ifdef LV_OWT_TX_CRC_EN
    localparam int CHK_W = 4;
`else
    localparam int CHK_W = 1;
`endif
    localparam int WR_LEN = 3 + REG_AW + REG_DW + CHK_W;
    localparam int RD_LEN = 3 + REG_AW + CHK_W;
    localparam int CW     = $clog2(BIT_CYC);
    localparam int IW     = $clog2(WR_LEN);
    localparam int GW     = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    typedef enum logic [1:0] {IDLE, TX, GAP} state_t;

    state_t            state_q, state_d;
    logic              arm_q, arm_d;
    logic              wr_q, wr_d;
    logic [REG_AW-1:0] addr_q, addr_d;
    logic [REG_DW-1:0] data_q, data_d;
    logic [CW-1:0]     cyc_q, cyc_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic              line_q, line_d;
    logic              ack_q, ack_d;

    logic [CHK_W-1:0]  chk;
    logic [WR_LEN-1:0] frame_w;
    logic [WR_LEN-1:0] frame_r;
    logic [IW-1:0]     nidx;
    logic [IW-1:0]     last_idx;

`ifdef LV_OWT_TX_CRC_EN
    // Serial CRC-4 step, poly x^4+x+1, message fed MSB first.
    function automatic logic [3:0] crc4_step(input logic [3:0] c, input logic b);
        logic fb;
        fb = c[3] ^ b;
        return {c[2:0], 1'b0} ^ {2'b00, fb, fb};
    endfunction

    always_comb begin
        chk = crc4_step(4'h0, wr_q);
        for (int i = REG_AW - 1; i >= 0; i--) chk = crc4_step(chk, addr_q[i]);
        if (wr_q) begin
            for (int i = REG_DW - 1; i >= 0; i--) chk = crc4_step(chk, data_q[i]);
        end
    end
`else
    assign chk = wr_q ? ^{wr_q, addr_q, data_q} : ^{wr_q, addr_q};
`endif

    // Read frames are left-aligned; the unused tail is never reached.
    always_comb begin
        if (wr_q) frame_w = {1'b0, 1'b1, addr_q, data_q, chk, 1'b1};
        else      frame_w = {1'b0, 1'b0, addr_q, chk, 1'b1, {REG_DW{1'b1}}};
        for (int i = 0; i < WR_LEN; i++) frame_r[i] = frame_w[WR_LEN-1-i];
    end

    assign nidx     = idx_q + IW'(1);
    assign last_idx = wr_q ? IW'(WR_LEN - 1) : IW'(RD_LEN - 1);

    always_comb begin
        state_d = state_q;
        arm_d   = arm_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cyc_d   = cyc_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        line_d  = line_q;
        ack_d   = 1'b0;
        case (state_q)
            IDLE: begin
                line_d = 1'b1;
                if (!i_spi_owt_wr_req && !i_spi_owt_rd_req) begin
                    arm_d = 1'b1;
                end else if (arm_q) begin
                    state_d = TX;
                    arm_d   = 1'b0;
                    wr_d    = i_spi_owt_wr_req;
                    addr_d  = i_spi_owt_addr;
                    data_d  = i_spi_owt_data;
                    cyc_d   = '0;
                    idx_d   = '0;
                    line_d  = 1'b0;
                end
            end
            TX: begin
                if (cyc_q == CW'(BIT_CYC - 1)) begin
                    cyc_d = '0;
                    if (idx_q == last_idx) begin
                        state_d = GAP;
                        gap_d   = '0;
                        line_d  = 1'b1;
                        // Ack only the request that is still being held.
                        ack_d   = wr_q ? i_spi_owt_wr_req : i_spi_owt_rd_req;
                    end else begin
                        idx_d  = nidx;
                        line_d = frame_r[nidx];
                    end
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            GAP: begin
                line_d = 1'b1;
                if (gap_q == GW'(GAP_CYC - 1)) state_d = IDLE;
                else                           gap_d   = gap_q + GW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            arm_q   <= 1'b1;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            cyc_q   <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
            line_q  <= 1'b1;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            arm_q   <= arm_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cyc_q   <= cyc_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            line_q  <= line_d;
            ack_q   <= ack_d;
        end
    end

    assign o_owt_tx_line    = line_q;
    assign o_owt_tx_spi_ack = ack_q;
    assign o_owt_tx_busy    = (state_q != IDLE);

endmodule
